// File: rtl/perceptron_weight_loader.sv
// perceptron_weight_loader: captures bias and two weights, then shifts each word MSB-first
// into perceptron_dp's serial load port, with field select, busy and done flags.
module perceptron_weight_loader #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic [WIDTH-1:0] b_par_i,
    input  logic [WIDTH-1:0] w0_par_i,
    input  logic [WIDTH-1:0] w1_par_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [1:0]       W1W0b_en_o,
    output logic             b_o,
    output logic             W0_o,
    output logic             W1_o
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [2:0] {IDLE, SH_B, SH_W0, SH_W1, DONE} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sh_b, sh_w0, sh_w1;

    // Outputs reflect the state held before each edge, so every field lags the accept edge by one cycle
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            sh_b       <= '0;
            sh_w0      <= '0;
            sh_w1      <= '0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            W1W0b_en_o <= 2'b00;
            b_o        <= 1'b0;
            W0_o       <= 1'b0;
            W1_o       <= 1'b0;
        end else begin
            busy_o     <= state == SH_B || state == SH_W0 || state == SH_W1;
            done_o     <= state == DONE;
            W1W0b_en_o <= state == SH_B ? 2'b01 : state == SH_W0 ? 2'b10 : state == SH_W1 ? 2'b11 : 2'b00;
            b_o        <= state == SH_B && sh_b[cnt];
            W0_o       <= state == SH_W0 && sh_w0[cnt];
            W1_o       <= state == SH_W1 && sh_w1[cnt];
            case (state)
                IDLE: if (start_i) begin
                    sh_b  <= b_par_i;
                    sh_w0 <= w0_par_i;
                    sh_w1 <= w1_par_i;
                    cnt   <= LAST;
                    state <= SH_B;
                end
                SH_B, SH_W0, SH_W1: begin
                    cnt <= cnt == '0 ? LAST : cnt - 1'b1;
                    if (cnt == '0)
                        state <= state == SH_B ? SH_W0 : state == SH_W0 ? SH_W1 : DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_perceptron_weight_loader.sv
// tb_perceptron_weight_loader: per-cycle scoreboard of all outputs plus a receiver model
// that shifts left LSB-in, checked against table vectors and multi-cycle corner cases.
module tb_perceptron_weight_loader;
    localparam int W = 8;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic [1:0] en;
        logic       b;
        logic       w0;
        logic       w1;
    } out_t;

    typedef struct {
        logic [W-1:0] b, w0, w1;
        int           sum11;
    } vec_t;

    logic         clk = 0, reset = 0, start = 0;
    logic [W-1:0] b_par = 0, w0_par = 0, w1_par = 0;
    logic         busy, done, b_o, W0_o, W1_o;
    logic [1:0]   en;

    int           errors = 0, checks = 0, cyc = 0, busy_cnt = 0, done_cnt = 0;
    out_t         q[$];
    int           acc_cyc[$];
    logic         armed = 0;
    logic [W-1:0] rb = 0, rw0 = 0, rw1 = 0;
    vec_t         tbl[6];

    always #5 clk = ~clk;

    perceptron_weight_loader #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start_i(start),
        .b_par_i(b_par), .w0_par_i(w0_par), .w1_par_i(w1_par),
        .busy_o(busy), .done_o(done), .W1W0b_en_o(en),
        .b_o(b_o), .W0_o(W0_o), .W1_o(W1_o)
    );

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endfunction

    // One idle record for the accept edge, W records per field, then the done record
    function automatic void push_seq(input logic [W-1:0] b, input logic [W-1:0] w0, input logic [W-1:0] w1);
        out_t r;
        q.push_back('0);
        for (int f = 0; f < 3; f++)
            for (int k = W - 1; k >= 0; k--) begin
                r      = '0;
                r.busy = 1'b1;
                r.en   = 2'(f + 1);
                r.b    = f == 0 && b[k];
                r.w0   = f == 1 && w0[k];
                r.w1   = f == 2 && w1[k];
                q.push_back(r);
            end
        r      = '0;
        r.done = 1'b1;
        q.push_back(r);
    endfunction

    always @(negedge clk) begin
        out_t a, e;
        cyc++;
        a = {busy, done, en, b_o, W0_o, W1_o};
        if (armed) begin
            e = '0;
            if (q.size() > 0) e = q.pop_front();
            chk("outputs", 32'(a), 32'(e));
        end
        if (!reset) begin
            armed = 1;
            q.delete();
            rb = 0; rw0 = 0; rw1 = 0;
        end else begin
            if (en == 2'b01) rb = {rb[W-2:0], b_o};
            if (en == 2'b10) rw0 = {rw0[W-2:0], W0_o};
            if (en == 2'b11) rw1 = {rw1[W-2:0], W1_o};
            busy_cnt += int'(busy);
            done_cnt += int'(done);
            if (start && q.size() == 0) begin
                push_seq(b_par, w0_par, w1_par);
                acc_cyc.push_back(cyc);
                busy_cnt = 0;
                done_cnt = 0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_done(input logic [W-1:0] b, input logic [W-1:0] w0, input logic [W-1:0] w1);
        int n = 0;
        while (!done && n < 100) begin
            step();
            n++;
        end
        chk("done_timeout", 32'(n < 100), 32'd1);
        step();
        chk("done_single_cycle", 32'(done), 32'd0);
        chk("done_pulses", 32'(done_cnt), 32'd1);
        chk("busy_cycles", 32'(busy_cnt), 32'(3 * W));
        chk("rx_b", 32'(rb), 32'(b));
        chk("rx_w0", 32'(rw0), 32'(w0));
        chk("rx_w1", 32'(rw1), 32'(w1));
    endtask

    task automatic launch(input logic [W-1:0] b, input logic [W-1:0] w0, input logic [W-1:0] w1);
        b_par = b; w0_par = w0; w1_par = w1;
        start = 1;
        step();
        start = 0;
        b_par = W'($urandom); w0_par = W'($urandom); w1_par = W'($urandom);
    endtask

    initial begin
        tbl[0] = '{8'h5A, 8'hC3, 8'h81, -98};
        tbl[1] = '{8'hFD, 8'h02, 8'h01, 0};
        tbl[2] = '{8'h80, 8'h7F, 8'hFF, -2};
        tbl[3] = '{8'hFF, 8'h80, 8'h7F, -2};
        tbl[4] = '{8'h00, 8'h00, 8'h00, 0};
        tbl[5] = '{8'h01, 8'hFE, 8'h55, 84};

        repeat (3) step();
        chk("reset_outputs", 32'({busy, done, en, b_o, W0_o, W1_o}), 32'd0);
        reset = 1;
        repeat (2) step();

        for (int i = 0; i < 6; i++) begin
            launch(tbl[i].b, tbl[i].w0, tbl[i].w1);
            wait_done(tbl[i].b, tbl[i].w0, tbl[i].w1);
            chk("rx_sum_x11", 32'($signed(rw0) + $signed(rw1) + $signed(rb)), 32'(tbl[i].sum11));
            repeat (2) step();
        end

        // Loopback with X0=0, X1=1 on the bias=-3, w0=2, w1=1 load
        launch(8'hFD, 8'h02, 8'h01);
        wait_done(8'hFD, 8'h02, 8'h01);
        chk("rx_sum_x01", 32'($signed(rw1) + $signed(rb)), 32'(-2));

        // Start pulse with other data five cycles into a load must be ignored
        launch(8'h5A, 8'hC3, 8'h81);
        repeat (4) step();
        b_par = 8'h11; w0_par = 8'h22; w1_par = 8'h33;
        start = 1;
        step();
        start = 0;
        wait_done(8'h5A, 8'hC3, 8'h81);
        repeat (30) step();
        chk("no_second_seq_busy", 32'(busy), 32'd0);
        chk("no_second_seq_acc", 32'(acc_cyc.size() > 0 ? cyc - acc_cyc[acc_cyc.size()-1] > 30 : 0), 32'd1);

        // Reset twelve edges after accept, in the middle of W0
        launch(8'hA5, 8'h3C, 8'h18);
        repeat (11) step();
        reset = 0;
        step();
        chk("abort_outputs", 32'({busy, done, en, b_o, W0_o, W1_o}), 32'd0);
        reset = 1;
        repeat (3) step();
        chk("abort_no_done", 32'(done), 32'd0);
        launch(8'h96, 8'h69, 8'hE7);
        wait_done(8'h96, 8'h69, 8'hE7);

        // Start held high: second accept 3*W+2 cycles after the first
        acc_cyc.delete();
        b_par = 8'h3A; w0_par = 8'hB5; w1_par = 8'h4E;
        start = 1;
        for (int n = 0; n < 100 && acc_cyc.size() < 2; n++) step();
        start = 0;
        chk("b2b_accepts", 32'(acc_cyc.size()), 32'd2);
        if (acc_cyc.size() >= 2) chk("b2b_period", 32'(acc_cyc[1] - acc_cyc[0]), 32'(3 * W + 2));
        wait_done(8'h3A, 8'hB5, 8'h4E);
        repeat (3) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
